// File: rtl/fifo_drain_pkg.sv
// rtl/fifo_drain_pkg.sv - shared types and default widths for the FIFO stream drain
package fifo_drain_pkg;

  localparam int DEF_FIFO_WIDTH = 16;
  localparam int DEF_SKID_DEPTH = 3;
  localparam int DEF_CNT_WIDTH  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } drain_state_e;

endpackage

// File: rtl/fifo_stream_drain_if.sv
// rtl/fifo_stream_drain_if.sv - valid/ready output stream carrying drained FIFO words
import fifo_drain_pkg::*;

interface fifo_stream_drain_if #(
  parameter int WIDTH = DEF_FIFO_WIDTH
);
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;

  modport master (output m_valid, output m_data, input m_ready);
  modport slave  (input m_valid, input m_data, output m_ready);
endinterface

// File: rtl/fifo_drain_skid_buf.sv
// rtl/fifo_drain_skid_buf.sv - circular skid buffer; DEPTH need not be a power of two
module fifo_drain_skid_buf
  import fifo_drain_pkg::*;
#(
  parameter int DEPTH = DEF_SKID_DEPTH,
  parameter int WIDTH = DEF_FIFO_WIDTH,
  parameter int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [OCC_W-1:0] occ_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
    if (push_i && !pop_i)      occ_d = occ_q + 1'b1;
    else if (!push_i && pop_i) occ_d = occ_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push_i) mem_q[wr_ptr_q] <= push_data_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  assign occ_o  = occ_q;
  assign head_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/fifo_stream_drain.sv
// rtl/fifo_stream_drain.sv - drains a synchronous FIFO into a valid/ready stream
module fifo_stream_drain
  import fifo_drain_pkg::*;
#(
  parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
  parameter int SKID_DEPTH = DEF_SKID_DEPTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [FIFO_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  fifo_stream_drain_if.master   m,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  word_count
);

  localparam int OCC_W = $clog2(SKID_DEPTH + 1);

  drain_state_e         state_q, state_d;
  logic                 pend_q;
  logic [CNT_WIDTH-1:0] word_count_q, word_count_d;
  logic [OCC_W-1:0]     occ;
  logic [OCC_W:0]       inflight;
  logic                 beat;

  // Space check counts the word already in flight so the buffer can never overflow.
  assign inflight   = {1'b0, occ} + {{OCC_W{1'b0}}, pend_q};
  assign fifo_rd_en = (state_q == RUN) && !fifo_empty &&
                      (inflight < (OCC_W + 1)'(SKID_DEPTH));
  assign m.m_valid  = (occ != '0);
  assign beat       = m.m_valid && m.m_ready;

  fifo_drain_skid_buf #(
    .DEPTH (SKID_DEPTH),
    .WIDTH (FIFO_WIDTH),
    .OCC_W (OCC_W)
  ) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (pend_q),
    .push_data_i (fifo_dout),
    .pop_i       (beat),
    .occ_o       (occ),
    .head_o      (m.m_data)
  );

  always_comb begin
    state_d      = state_q;
    word_count_d = beat ? word_count_q + 1'b1 : word_count_q;
    unique case (state_q)
      IDLE:    if (enable) state_d = RUN;
      RUN:     if (!enable) state_d = DRAIN;
      DRAIN: begin
        if (enable)                        state_d = RUN;
        else if (!pend_q && occ == '0)     state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pend_q       <= 1'b0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      pend_q       <= fifo_rd_en;
      word_count_q <= word_count_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign word_count = word_count_q;

endmodule

// File: tb/tb_fifo_stream_drain.sv
// tb/tb_fifo_stream_drain.sv - randomized and directed bench with a queue-based reference model
module tb_fifo_stream_drain;
  import fifo_drain_pkg::*;

  localparam int W  = 16;
  localparam int D  = 3;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [W-1:0]  fifo_dout = '0;
  logic          fifo_rd_en;
  logic          busy;
  logic [CW-1:0] word_count;

  fifo_stream_drain_if #(.WIDTH(W)) s_if ();

  fifo_stream_drain #(.FIFO_WIDTH(W), .SKID_DEPTH(D), .CNT_WIDTH(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_rd_en (fifo_rd_en),
    .m          (s_if),
    .busy       (busy),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [W-1:0]  fifo_q[$];
  logic [W-1:0]  exp_q[$];
  int            rdt_q[$];
  logic [W-1:0]  dout_next = '0;
  bit            dout_load = 0;
  logic [CW-1:0] wc_model = '0;
  bit            prev_hold = 0;
  logic [W-1:0]  prev_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: every word read is delivered in order two cycles or more after its read.
  always @(negedge clk) begin
    bit exp_v;
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      rdt_q.delete();
      wc_model  = '0;
      prev_hold = 0;
      dout_load = 0;
    end else begin
      if (fifo_rd_en) begin
        check("rd_while_empty", fifo_empty, 0);
        check("outstanding_bound", rdt_q.size() < D, 1);
      end
      exp_v = (rdt_q.size() > 0) && (rdt_q[0] <= cyc - 2);
      check("m_valid", s_if.m_valid, exp_v);
      if (exp_v && s_if.m_valid) check("m_data", s_if.m_data, exp_q[0]);
      if (prev_hold) check("hold_data", s_if.m_data, prev_data);
      check("word_count", word_count, wc_model);
      if (s_if.m_valid && s_if.m_ready && exp_v) begin
        void'(exp_q.pop_front());
        void'(rdt_q.pop_front());
        wc_model++;
      end
      prev_hold = s_if.m_valid && !s_if.m_ready;
      prev_data = s_if.m_data;
      if (fifo_rd_en && fifo_q.size() > 0) begin
        dout_next = fifo_q.pop_front();
        dout_load = 1;
        exp_q.push_back(dout_next);
        rdt_q.push_back(cyc);
      end
    end
  end

  // External FIFO: registered read data, empty flag updated after the edge.
  always @(posedge clk) begin
    #1;
    if (dout_load) begin
      fifo_dout = dout_next;
      dout_load = 0;
    end
    fifo_empty = (fifo_q.size() == 0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] w);
    fifo_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  initial begin
    int n_rd, n_v, n_idle, first_rd, last_rd, first_v, first_idle, bound;
    logic [W-1:0] got[$];
    int beat_c[$];

    s_if.m_ready = 1'b0;

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    check("rst_rd_en", fifo_rd_en, 0);
    check("rst_m_valid", s_if.m_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_word_count", word_count, 0);
    check("rst_m_data", s_if.m_data, 0);
    tick();
    rst_n = 1'b1;

    // Streaming 1..8 with m_ready high
    for (int i = 1; i <= 8; i++) push(W'(i));
    enable = 1'b1;
    s_if.m_ready = 1'b1;
    n_rd = 0; first_rd = -1; last_rd = -1; first_v = -1;
    got.delete(); beat_c.delete();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (fifo_rd_en) begin
        if (first_rd < 0) first_rd = c;
        last_rd = c;
        n_rd++;
      end
      if (s_if.m_valid && s_if.m_ready) begin
        if (first_v < 0) first_v = c;
        got.push_back(s_if.m_data);
        beat_c.push_back(c);
      end
    end
    check("stream_rd_count", n_rd, 8);
    check("stream_rd_span", last_rd - first_rd, 7);
    check("stream_latency", first_v - first_rd, 2);
    check("stream_beats", got.size(), 8);
    if (got.size() == 8) begin
      for (int i = 0; i < 8; i++) check("stream_order", got[i], i + 1);
      check("stream_beat_span", beat_c[7] - beat_c[0], 7);
    end
    check("stream_word_count", word_count, 8);

    // Backpressure: only the skid depth worth of reads, head held
    tick();
    s_if.m_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push(W'(i));
    n_rd = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (fifo_rd_en) n_rd++;
    end
    check("bp_rd_count", n_rd, 3);
    check("bp_rd_en_low", fifo_rd_en, 0);
    check("bp_m_valid", s_if.m_valid, 1);
    check("bp_m_data", s_if.m_data, 16'h0001);
    tick();
    s_if.m_ready = 1'b1;
    got.delete();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (s_if.m_valid && s_if.m_ready) got.push_back(s_if.m_data);
    end
    check("bp_beats", got.size(), 8);
    if (got.size() == 8)
      for (int i = 0; i < 8; i++) check("bp_order", got[i], i + 1);
    check("bp_word_count", word_count, 16);

    // Empty FIFO while enabled
    n_rd = 0; n_v = 0; n_idle = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (fifo_rd_en) n_rd++;
      if (s_if.m_valid) n_v++;
      if (!busy) n_idle++;
    end
    check("empty_rd_en", n_rd, 0);
    check("empty_m_valid", n_v, 0);
    check("empty_not_busy", n_idle, 0);

    // Disable mid-stream with pend=1, occ=2
    tick();
    s_if.m_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push(W'(i));
    n_rd = 0; bound = 0;
    while (n_rd < 3 && bound < 20) begin
      @(negedge clk);
      if (fifo_rd_en) n_rd++;
      bound++;
    end
    check("dis_setup_timeout", n_rd, 3);
    tick();
    enable = 1'b0;
    s_if.m_ready = 1'b1;
    n_rd = 0; first_idle = -1; last_rd = -1;
    got.delete();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (fifo_rd_en) n_rd++;
      if (s_if.m_valid && s_if.m_ready) begin
        got.push_back(s_if.m_data);
        last_rd = c;
      end
      if (!busy && first_idle < 0) first_idle = c;
    end
    check("dis_no_reads", n_rd, 0);
    check("dis_beats", got.size(), 3);
    if (got.size() == 3)
      for (int i = 0; i < 3; i++) check("dis_order", got[i], i + 1);
    check("dis_busy_fall", first_idle - last_rd, 2);
    check("dis_word_count", word_count, 19);
    tick();
    fifo_q.delete();
    fifo_empty = 1'b1;

    // Reset while two words are buffered
    enable = 1'b1;
    s_if.m_ready = 1'b0;
    push(16'h00A1);
    push(16'h00A2);
    repeat (6) @(negedge clk);
    check("rst2_pre_valid", s_if.m_valid, 1);
    #2;
    rst_n = 1'b0;
    enable = 1'b0;
    #1;
    check("rst2_m_valid", s_if.m_valid, 0);
    check("rst2_busy", busy, 0);
    check("rst2_rd_en", fifo_rd_en, 0);
    check("rst2_word_count", word_count, 0);
    fifo_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    enable = 1'b1;
    s_if.m_ready = 1'b1;
    n_v = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (s_if.m_valid) n_v++;
    end
    check("rst2_no_stale", n_v, 0);
    check("rst2_count_zero", word_count, 0);

    // Randomized traffic against the model
    tick();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(19) == 0) enable = ~enable;
      s_if.m_ready = ($urandom_range(3) != 0);
      if ($urandom_range(1) == 0 && fifo_q.size() < 16) push(W'($urandom));
      tick();
    end
    enable = 1'b0;
    s_if.m_ready = 1'b1;
    bound = 0;
    while (busy && bound < 200) begin
      tick();
      bound++;
    end
    @(negedge clk);
    check("final_drain_idle", busy, 0);
    check("final_outstanding", rdt_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
